// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache line fill unit.
//   fill_state_e   : fill engine states {IDLE, WB, RD, DONE}
//   LINE_WORDS_DEF : default words per cache line
//   BEAT_BYTES     : bytes per memory beat (32-bit bus)
//   line_off()     : number of line-offset address bits for a given line size
package cache_fill_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int BEAT_BYTES     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  // log2 of the line size in bytes; LINE_WORDS is a power of two.
  function automatic int line_off(input int line_words);
    return $clog2(line_words * BEAT_BYTES);
  endfunction

endpackage

// File: rtl/cache_line_buffer.sv
// Line-sized register file shared by writeback and refill.
//   clk_i, rst_ni : clock, async active-low reset (clears all words)
//   load_i        : bulk load of load_line_i (victim line), word 0 in LSBs
//   wr_en_i       : indexed word write of wr_data_i at wr_idx_i (refill data)
//   rd_idx_i      : indexed read, result on rd_data_o (writeback data)
//   line_o        : whole line, word 0 in LSBs
module cache_line_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         load_i,
  input  logic [LINE_WORDS*DATA_W-1:0] load_line_i,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic [LINE_WORDS*DATA_W-1:0] line_o
);

  logic [LINE_WORDS-1:0][DATA_W-1:0] words_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
    end else begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (load_i)
          words_q[w] <= load_line_i[w*DATA_W +: DATA_W];
        else if (wr_en_i && (wr_idx_i == IDX_W'(w)))
          words_q[w] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = words_q[rd_idx_i];
  assign line_o    = words_q;

endmodule

// File: rtl/cache_line_fill_unit.sv
// Cache line fill engine between the data-cache controller and main memory.
// Clean miss: read one line. Dirty miss: write the victim line back, then
// read the new line. Completion is a one-cycle DONE state that strobes the
// line into the cache array and pulses cache_ready_o (clean) or
// mem_ready_o (dirty).
//   Controller side : refill_req_i, wb_req_i, miss_addr_i, victim_addr_i,
//                     victim_line_i, busy_o, fill_line_o, fill_we_o,
//                     cache_ready_o, mem_ready_o
//   Memory side     : mem_req_o/mem_gnt_i handshake per beat, mem_we_o,
//                     mem_addr_o, mem_wdata_o, in-order mem_rvalid_i/mem_rdata_i
//   Perf counters   : wb_cnt_o, busy_cyc_o, built only when
//                     CACHE_FILL_PERF_CNT_EN is defined, else tied to 0
module cache_line_fill_unit
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         refill_req_i,
  input  logic                         wb_req_i,
  input  logic [ADDR_W-1:0]            miss_addr_i,
  input  logic [ADDR_W-1:0]            victim_addr_i,
  input  logic [LINE_WORDS*DATA_W-1:0] victim_line_i,
  output logic                         busy_o,
  output logic [LINE_WORDS*DATA_W-1:0] fill_line_o,
  output logic                         fill_we_o,
  output logic                         cache_ready_o,
  output logic                         mem_ready_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic [31:0]                  wb_cnt_o,
  output logic [31:0]                  busy_cyc_o
);

  localparam int OFF   = line_off(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_WORDS);
  // One extra bit so a counter can hold LINE_WORDS itself.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_WORDS);

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] b;
    b          = a;
    b[OFF-1:0] = '0;
    return b;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + (ADDR_W'(idx) << 2);
  endfunction

  fill_state_e            state_q, state_d;
  logic                   job_dirty_q;
  logic [ADDR_W-1:0]      vic_base_q, miss_base_q;
  logic [CNT_W-1:0]       wr_idx_q, iss_idx_q, rcv_idx_q;
  logic [DATA_W-1:0]      buf_rd_data;

  logic idle_wb_start, idle_rd_start, rd_accept;

  assign idle_wb_start = (state_q == IDLE) && wb_req_i;
  assign idle_rd_start = (state_q == IDLE) && !wb_req_i && refill_req_i;
  // Guarded so a surplus response can never overrun the line.
  assign rd_accept     = (state_q == RD) && mem_rvalid_i && (rcv_idx_q < FULL);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    fill_we_o     = 1'b0;
    cache_ready_o = 1'b0;
    mem_ready_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_req_i)          state_d = WB;
        else if (refill_req_i) state_d = RD;
      end
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = beat_addr(vic_base_q, wr_idx_q);
        mem_wdata_o = buf_rd_data;
        if (mem_gnt_i && (wr_idx_q == LAST)) state_d = RD;
      end
      RD: begin
        mem_req_o = (iss_idx_q < FULL);
        if (mem_req_o) mem_addr_o = beat_addr(miss_base_q, iss_idx_q);
        if (rd_accept && (rcv_idx_q == LAST)) state_d = DONE;
      end
      DONE: begin
        fill_we_o     = 1'b1;
        cache_ready_o = !job_dirty_q;
        mem_ready_o   = job_dirty_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Job registers and beat counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_dirty_q <= 1'b0;
      vic_base_q  <= '0;
      miss_base_q <= '0;
      wr_idx_q    <= '0;
      iss_idx_q   <= '0;
      rcv_idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (idle_wb_start) begin
            vic_base_q  <= line_base(victim_addr_i);
            miss_base_q <= line_base(miss_addr_i);
            job_dirty_q <= 1'b1;
          end else if (idle_rd_start) begin
            miss_base_q <= line_base(miss_addr_i);
            job_dirty_q <= 1'b0;
          end
        end
        WB: begin
          if (mem_gnt_i) wr_idx_q <= (wr_idx_q == LAST) ? '0 : wr_idx_q + 1'b1;
        end
        RD: begin
          // Issue and receive run concurrently and are counted independently.
          if (mem_req_o && mem_gnt_i) iss_idx_q <= iss_idx_q + 1'b1;
          if (rd_accept)              rcv_idx_q <= rcv_idx_q + 1'b1;
        end
        DONE: begin
          wr_idx_q  <= '0;
          iss_idx_q <= '0;
          rcv_idx_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Victim data is loaded as the job starts; refill words then overwrite
  // it in place, so one buffer serves both directions.
  cache_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (idle_wb_start),
    .load_line_i (victim_line_i),
    .wr_en_i     (rd_accept),
    .wr_idx_i    (rcv_idx_q[IDX_W-1:0]),
    .wr_data_i   (mem_rdata_i),
    .rd_idx_i    (wr_idx_q[IDX_W-1:0]),
    .rd_data_o   (buf_rd_data),
    .line_o      (fill_line_o)
  );

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
`ifdef CACHE_FILL_PERF_CNT_EN
  logic [31:0] wb_cnt_q, busy_cyc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_cnt_q   <= '0;
      busy_cyc_q <= '0;
    end else begin
      if (idle_wb_start) wb_cnt_q   <= wb_cnt_q + 32'd1;
      if (busy_o)        busy_cyc_q <= busy_cyc_q + 32'd1;
    end
  end

  assign wb_cnt_o   = wb_cnt_q;
  assign busy_cyc_o = busy_cyc_q;
`else
  assign wb_cnt_o   = '0;
  assign busy_cyc_o = '0;
`endif

endmodule

// File: tb/tb_cache_line_fill_unit.sv
// Self-checking bench for cache_line_fill_unit. A memory model answers
// beats; a per-cycle monitor checks every granted beat, every completion
// and address/data stability against expectations built from the job
// description (line base, beat list, expected fill line).
module tb_cache_line_fill_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LW     = 4;
  localparam int LBYTES = LW * 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   refill_req, wb_req;
  logic [ADDR_W-1:0]      miss_addr, victim_addr;
  logic [LW*DATA_W-1:0]   victim_line;
  logic                   busy_o, fill_we_o, cache_ready_o, mem_ready_o;
  logic [LW*DATA_W-1:0]   fill_line_o;
  logic                   mem_req_o, mem_we_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic [DATA_W-1:0]      mem_wdata_o;
  logic                   mem_gnt_i, mem_rvalid_i;
  logic [DATA_W-1:0]      mem_rdata_i;
  logic [31:0]            wb_cnt_o, busy_cyc_o;

  cache_line_fill_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .refill_req_i(refill_req), .wb_req_i(wb_req),
    .miss_addr_i(miss_addr), .victim_addr_i(victim_addr), .victim_line_i(victim_line),
    .busy_o(busy_o), .fill_line_o(fill_line_o), .fill_we_o(fill_we_o),
    .cache_ready_o(cache_ready_o), .mem_ready_o(mem_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_cnt_o(wb_cnt_o), .busy_cyc_o(busy_cyc_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] data; int ready; } rsp_t;

  beat_t exp_beats[$];
  beat_t gnt_log[$];
  rsp_t  pend[$];
  logic [31:0] memw [logic [31:0]];

  logic [LW*DATA_W-1:0] exp_line;
  bit   exp_dirty, job_open;
  int   done_cnt = 0, job_busy = 0, cr_cnt = 0, mr_cnt = 0, rv_cnt = 0, stall_obs = 0;
  bit   zero_wait = 1, hold_rsp = 0, stray_en = 0, lat_check = 0;
  int   gnt_pct = 100, rsp_max_delay = 0;
  int   stall_beat = -1, stall_left = 0, wb_granted = 0;
  int   cyc = 0;

  logic        prev_req, prev_gnt, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model + per-cycle monitor. Outputs are registered-state driven,
  // so they are sampled here (between edges) and new inputs driven after.
  always @(negedge clk) begin : mon
    logic g, rv;
    logic [31:0] rd;
    beat_t e;
    cyc++;
    if (!rst_n) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0;
    end else begin
      if (busy_o) job_busy++;
      if (cache_ready_o) cr_cnt++;
      if (mem_ready_o)   mr_cnt++;
      chk("pulse_without_we", (cache_ready_o | mem_ready_o) & ~fill_we_o, 0);
      if (prev_req && !prev_gnt && mem_req_o) begin
        stall_obs++;
        chk("stall_addr", mem_addr_o, prev_addr);
        chk("stall_we", mem_we_o, prev_we);
        if (mem_we_o) chk("stall_wdata", mem_wdata_o, prev_wdata);
      end
      g = 1'b0;
      if (mem_req_o) begin
        g = zero_wait ? 1'b1 : ($urandom_range(0, 99) < gnt_pct);
        if (mem_we_o && wb_granted == stall_beat && stall_left > 0) begin
          g = 1'b0; stall_left--;
        end
      end else if (!zero_wait) begin
        g = 1'($urandom_range(0, 1));
      end
      if (mem_req_o && g) begin
        gnt_log.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
        if (exp_beats.size() == 0) chk("beat_unexpected", mem_addr_o, 0);
        else begin
          e = exp_beats.pop_front();
          chk("beat_we", mem_we_o, e.we);
          chk("beat_addr", mem_addr_o, e.addr);
          if (e.we) chk("beat_wdata", mem_wdata_o, e.data);
        end
        if (mem_we_o) wb_granted++;
        else pend.push_back('{mem_word(mem_addr_o),
                              cyc + (zero_wait ? 1 : $urandom_range(0, rsp_max_delay))});
      end
      rv = 1'b0; rd = $urandom;
      if (pend.size() > 0 && !hold_rsp && pend[0].ready <= cyc &&
          (zero_wait || $urandom_range(0, 3) != 0)) begin
        rv = 1'b1; rd = pend.pop_front().data; rv_cnt++;
      end else if (stray_en && (!busy_o || mem_we_o || fill_we_o) && $urandom_range(0, 2) == 0) begin
        rv = 1'b1;
      end
      if (fill_we_o) begin
        chk("done_expected", job_open, 1);
        chk("fill_line", fill_line_o, exp_line);
        chk("cache_ready", cache_ready_o, !exp_dirty);
        chk("mem_ready", mem_ready_o, exp_dirty);
        chk("beats_left", exp_beats.size(), 0);
        if (lat_check) chk("latency", job_busy, exp_dirty ? 2*LW+2 : LW+2);
        job_open = 1'b0;
        done_cnt++;
      end
      prev_req = mem_req_o; prev_gnt = g; prev_we = mem_we_o;
      prev_addr = mem_addr_o; prev_wdata = mem_wdata_o;
      mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    end
  end

  int done_before;

  // Build the job's expected beat list and line from its description.
  task automatic start_job(input bit dirty, input logic [31:0] maddr,
                           input logic [31:0] vaddr, input logic [LW*DATA_W-1:0] vline);
    logic [31:0] mbase, vbase;
    mbase = maddr & ~32'(LBYTES - 1);
    vbase = vaddr & ~32'(LBYTES - 1);
    exp_beats.delete();
    if (dirty)
      for (int i = 0; i < LW; i++) exp_beats.push_back('{1'b1, vbase + 32'(4*i), vline[i*32 +: 32]});
    for (int i = 0; i < LW; i++) begin
      exp_beats.push_back('{1'b0, mbase + 32'(4*i), 32'h0});
      exp_line[i*32 +: 32] = mem_word(mbase + 32'(4*i));
    end
    exp_dirty = dirty; job_open = 1'b1; job_busy = 0; wb_granted = 0;
    done_before = done_cnt;
    miss_addr = maddr; victim_addr = vaddr; victim_line = vline;
    wb_req = dirty;
    refill_req = dirty ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_job(input bit chaos);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      if (fill_we_o) begin
        wb_req = 1'b0; refill_req = 1'b0;
        break;
      end
      if (t > 2000) begin
        chk("job_timeout", t, 0);
        wb_req = 1'b0; refill_req = 1'b0;
        break;
      end
      if (chaos && busy_o) begin
        wb_req = 1'($urandom_range(0, 1)); refill_req = 1'($urandom_range(0, 1));
        miss_addr = $urandom; victim_addr = $urandom;
        victim_line = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    @(negedge clk);
    chk("job_completed_once", done_cnt, done_before + 1);
  endtask

  logic [31:0] a_addr [4];
  logic [31:0] b_addr [8];
  int cr0, mr0, s0, r0;

  initial begin
    rst_n = 1'b0; refill_req = 1'b0; wb_req = 1'b0;
    miss_addr = '0; victim_addr = '0; victim_line = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_fill_line", fill_line_o, 0);
    chk("rst_outputs", {fill_we_o, cache_ready_o, mem_ready_o, mem_req_o, mem_we_o}, 0);
    chk("rst_addr_data", {mem_addr_o, mem_wdata_o}, 0);
    chk("rst_perf", {wb_cnt_o, busy_cyc_o}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Clean refill, zero-wait memory, known data.
    for (int i = 0; i < 4; i++) memw[32'h1230 + 32'(4*i)] = 32'hA0 + 32'(i);
    a_addr = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    lat_check = 1'b1; gnt_log.delete(); cr0 = cr_cnt; mr0 = mr_cnt;
    start_job(1'b0, 32'h0000_1234, 32'h0, '0);
    wait_job(1'b0);
    chk("A_line", fill_line_o, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("A_cycles", job_busy, 6);
    chk("A_cache_ready_pulses", cr_cnt - cr0, 1);
    chk("A_mem_ready_pulses", mr_cnt - mr0, 0);
    chk("A_beat_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("A_beat_addr", gnt_log[i].addr, a_addr[i]);

    // Dirty job: writeback then refill.
    b_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h3010, 32'h3014, 32'h3018, 32'h301C};
    gnt_log.delete(); cr0 = cr_cnt; mr0 = mr_cnt;
    start_job(1'b1, 32'h0000_3010, 32'h0000_2000, 128'h000000D3_000000D2_000000D1_000000D0);
    wait_job(1'b0);
    chk("B_cycles", job_busy, 10);
    chk("B_mem_ready_pulses", mr_cnt - mr0, 1);
    chk("B_cache_ready_pulses", cr_cnt - cr0, 0);
    chk("B_beat_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
      chk("B_beat_addr", gnt_log[i].addr, b_addr[i]);
      chk("B_beat_we", gnt_log[i].we, i < 4);
      if (i < 4) chk("B_beat_wdata", gnt_log[i].data, 32'hD0 + 32'(i));
    end
`ifdef CACHE_FILL_PERF_CNT_EN
    chk("perf_wb_cnt", wb_cnt_o, 1);
    chk("perf_busy_cyc", busy_cyc_o, 16);
`else
    chk("perf_wb_cnt_off", wb_cnt_o, 0);
    chk("perf_busy_cyc_off", busy_cyc_o, 0);
`endif
    lat_check = 1'b0;

    // Grant withheld 5 cycles on writeback beat 2.
    stall_beat = 2; stall_left = 5; s0 = stall_obs;
    start_job(1'b1, 32'h0000_5A5C, 32'h0000_7770, {$urandom, $urandom, $urandom, $urandom});
    wait_job(1'b0);
    chk("C_stall_cycles", stall_obs - s0, 5);
    stall_beat = -1;

    // Read responses held until 3 cycles after all grants.
    hold_rsp = 1'b1;
    start_job(1'b0, 32'h0000_9000, 32'h0, '0);
    for (int t = 0; t < 100 && exp_beats.size() != 0; t++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("D_no_early_done", fill_we_o, 0);
    end
    hold_rsp = 1'b0;
    wait_job(1'b0);

    // Randomized jobs: random grants, response delays, stray rvalids and
    // request/address noise while busy.
    zero_wait = 1'b0; gnt_pct = 70; rsp_max_delay = 3; stray_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      start_job(1'($urandom_range(0, 1)), $urandom, $urandom,
                {$urandom, $urandom, $urandom, $urandom});
      wait_job(1'b1);
    end

    // Reset in the middle of RD after two responses.
    zero_wait = 1'b1; stray_en = 1'b0; cr0 = cr_cnt; mr0 = mr_cnt;
    start_job(1'b0, 32'h0000_4444, 32'h0, '0);
    r0 = rv_cnt;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #2;
      if (rv_cnt - r0 >= 2) break;
    end
    chk("F_two_words_in", fill_line_o[63:0], {exp_line[63:32], exp_line[31:0]});
    rst_n = 1'b0;
    #1;
    chk("F_rst_busy", busy_o, 0);
    chk("F_rst_outputs", {fill_we_o, cache_ready_o, mem_ready_o, mem_req_o, mem_we_o}, 0);
    chk("F_rst_addr", mem_addr_o, 0);
    chk("F_rst_line", fill_line_o, 0);
    job_open = 1'b0; exp_beats.delete(); pend.delete();
    refill_req = 1'b0; wb_req = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    pend.push_back('{32'hDEAD_0001, 0});
    pend.push_back('{32'hDEAD_0002, 0});
    repeat (4) @(negedge clk);
    chk("F_stray_line", fill_line_o, 0);
    chk("F_stray_busy", busy_o, 0);
    chk("F_no_pulse", (cr_cnt - cr0) + (mr_cnt - mr0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_line_fill_unit.md
Name: cache_line_fill_unit

Overview:
- Memory-side engine directly downstream of the data-cache controller.
- On a clean miss, fetches one cache line from main memory. On a dirty miss, first writes the victim line back, then fetches the new line.
- Hands the filled line to the cache array and signals completion to the controller:
  - cache_ready_o after a clean-miss refill;
  - mem_ready_o after a dirty-miss writeback plus refill.
- Talks to memory over a word-serial request/grant bus with in-order read responses.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, memory bus word width; fixed at 32 (4-byte beats)
- LINE_WORDS, 4, words per cache line; power of two, 2..16

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- refill_req_i  in  1  clean-miss request, level; sampled only in IDLE
- wb_req_i  in  1  dirty-miss request, level; wins over refill_req_i; sampled only in IDLE
- miss_addr_i  in  ADDR_W  address of the missing access; low offset bits ignored
- victim_addr_i  in  ADDR_W  line address of the dirty victim; low offset bits ignored
- victim_line_i  in  LINE_WORDS*DATA_W  victim data; word 0 in the LSBs
- busy_o  in/out: out  1  high in any state other than IDLE
- fill_line_o  out  LINE_WORDS*DATA_W  assembled refill line; held until the next fill starts
- fill_we_o  out  1  one-cycle cache-array write strobe, asserted in DONE
- cache_ready_o  out  1  one-cycle pulse in DONE when the job was a clean refill
- mem_ready_o  out  1  one-cycle pulse in DONE when the job was writeback + refill
- mem_req_o  out  1  beat request valid
- mem_we_o  out  1  1 = write beat, 0 = read beat
- mem_addr_o  out  ADDR_W  beat byte address
- mem_wdata_o  out  DATA_W  write data
- mem_gnt_i  in  1  beat accepted this cycle when mem_req_o is high
- mem_rvalid_i  in  1  read data valid; responses return in request order
- mem_rdata_i  in  DATA_W  read data
- wb_cnt_o  out  32  writeback-job counter (optional feature)
- busy_cyc_o  out  32  busy-cycle counter (optional feature)

Behaviour:
- Reset values:
  - All outputs are 0; fill_line_o is 0.
  - State is IDLE; all counters, job flag and latched addresses are cleared.
- Addressing:
  - OFF = log2(LINE_WORDS*4).
  - Line base = addr with bits [OFF-1:0] forced to 0.
  - Beat i address = base + 4*i, where i runs 0..LINE_WORDS-1.
- State machine {IDLE, WB, RD, DONE}:
  - IDLE:
    - wb_req_i=1: latch both line bases, latch victim_line_i, set job_dirty=1, go to WB.
    - Otherwise refill_req_i=1: latch the miss base, set job_dirty=0, go to RD.
    - Neither request: stay in IDLE.
  - WB:
    - mem_req_o=1, mem_we_o=1, address and data selected by wr_idx.
    - Each cycle with mem_gnt_i: wr_idx++.
    - Grant on beat LINE_WORDS-1: wr_idx wraps to 0, go to RD the next cycle.
  - RD:
    - mem_req_o=1 and mem_we_o=0 while iss_idx < LINE_WORDS.
    - Each grant: iss_idx++.
    - Each mem_rvalid_i: store mem_rdata_i in fill word rcv_idx, then rcv_idx++.
    - Issue and receive proceed concurrently; a grant and a response in the same cycle are both counted.
    - A response in the same cycle as its own grant is legal.
    - When rcv_idx reaches LINE_WORDS, go to DONE.
  - DONE (exactly one cycle):
    - fill_we_o=1.
    - cache_ready_o = !job_dirty; mem_ready_o = job_dirty.
    - Clear the counters, go to IDLE.
    - Requests are ignored in DONE. The controller drops its request on the same edge, so the job does not retrigger.
- Counter widths: $clog2(LINE_WORDS)+1 bits, so the value LINE_WORDS is representable.
- Boundary conditions:
  - mem_rvalid_i outside RD is ignored.
  - A grant stalled indefinitely holds the FSM; beat address and data stay stable while mem_req_o is high and no grant has arrived.
  - Async reset mid-job aborts immediately with no completion pulse. Late memory responses after reset are ignored, because they arrive in IDLE.
  - Requests changing during a job have no effect.
- Latency with zero-wait memory (grant every cycle, rvalid the cycle after the grant):
  - Clean refill: LINE_WORDS+2 cycles from leaving IDLE to DONE.
  - Dirty job: 2*LINE_WORDS+2 cycles.

Optional Feature:
- Macro: CACHE_FILL_PERF_CNT_EN.
- Defined:
  - wb_cnt_o increments on entry to WB.
  - busy_cyc_o increments every cycle busy_o=1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package cache_fill_pkg holds:
  - the fill_state_e enum {IDLE, WB, RD, DONE};
  - the LINE_WORDS default;
  - the OFF computation function.
- One sub-module, cache_line_buffer: LINE_WORDS x DATA_W register file.
  - Indexed write port, used for received words.
  - Bulk load, used for the victim line.
  - Indexed read, which drives mem_wdata_o.
  - Flat line output, which drives fill_line_o.

Test Plan:
- Clean refill, miss_addr_i=0x0000_1234, zero-wait memory returning 0xA0..0xA3:
  - read beats go to 0x1230, 0x1234, 0x1238, 0x123C;
  - fill_line_o = {A3,A2,A1,A0};
  - cache_ready_o and fill_we_o pulse for 1 cycle in cycle 6;
  - mem_ready_o stays 0.
- Dirty job, victim 0x0000_2000 with line {D3..D0}, miss 0x0000_3010:
  - write beats to 0x2000..0x200C carry D0..D3 in order;
  - then read beats go to 0x3010..0x301C;
  - mem_ready_o pulses once; cache_ready_o stays 0.
- Grant withheld 5 cycles on beat 2 of WB: mem_addr_o and mem_wdata_o stay stable throughout and the beat completes once granted.
- Read responses delayed 3 cycles after all grants: no DONE occurs until 4 rvalids; the words land in order.
- rst_ni pulsed low during RD after 2 responses:
  - outputs go to 0 immediately; no pulse appears;
  - 2 stray rvalids after reset leave fill_line_o at 0.
- CACHE_FILL_PERF_CNT_EN defined, one clean job plus one dirty job, zero-wait memory:
  - wb_cnt_o = 1;
  - busy_cyc_o = 6 + 10 = 16.
